// File: rtl/ahb_to_apb_bridge_pkg.sv
// Shared definitions for the AHB-Lite to APB bridge: FSM states, AHB codes and APB4 helpers.
// The optional APB4 sideband (PSTRB/PPROT) is enabled with the AHB2APB_APB4_EN macro.
package ahb_to_apb_bridge_pkg;

    typedef enum logic [2:0] {
        StIdle   = 3'd0,
        StWWait  = 3'd1,
        StSetup  = 3'd2,
        StAccess = 3'd3,
        StErr1   = 3'd4,
        StErr2   = 3'd5
    } bridge_state_e;

    localparam logic [1:0] HtransIdle   = 2'b00;
    localparam logic [1:0] HtransBusy   = 2'b01;
    localparam logic [1:0] HtransNonseq = 2'b10;
    localparam logic [1:0] HtransSeq    = 2'b11;

    localparam logic HrespOkay  = 1'b0;
    localparam logic HrespError = 1'b1;

    localparam logic [2:0] HsizeByte = 3'b000;
    localparam logic [2:0] HsizeHalf = 3'b001;
    localparam logic [2:0] HsizeWord = 3'b010;

    // HPROT[0] is data/opcode (inverted into PPROT[2]), HPROT[1] is privileged.
    function automatic logic [2:0] apb4_pprot(input logic [3:0] hprot);
        return {~hprot[0], 1'b0, hprot[1]};
    endfunction

    function automatic logic is_ahb_active(input logic [1:0] htrans);
        return (htrans == HtransNonseq) || (htrans == HtransSeq);
    endfunction

endpackage

// File: rtl/ahb_apb_strb_gen.sv
// Combinational APB4 byte-strobe generator from AHB size and low address bits.
// Only instantiated when AHB2APB_APB4_EN is defined; reads always produce an all-zero strobe.
module ahb_apb_strb_gen
    import ahb_to_apb_bridge_pkg::*;
(
    input  logic [2:0] hsize_i,
    input  logic [1:0] addr_lo_i,
    input  logic       write_i,
    output logic [3:0] pstrb_o
);

    logic [3:0] strb_byte;
    logic [3:0] strb_half;

    always_comb begin
        strb_byte = 4'b0001 << addr_lo_i;
        strb_half = 4'b0011 << {addr_lo_i[1], 1'b0};
    end

    always_comb begin
        pstrb_o = 4'b0000;
        if (write_i) begin
            unique case (hsize_i)
                HsizeByte: pstrb_o = strb_byte;
                HsizeHalf: pstrb_o = strb_half;
                HsizeWord: pstrb_o = 4'b1111;
                // Wider than the 32-bit bus: treat as a full-word access.
                default:   pstrb_o = 4'b1111;
            endcase
        end
    end

endmodule

// File: rtl/ahb_to_apb_bridge.sv
// AHB-Lite slave to APB master bridge; stalls AHB for the whole APB transfer and maps PSLVERR
// to a two-cycle AHB ERROR response. Define AHB2APB_APB4_EN to add the PSTRB/PPROT outputs.
module ahb_to_apb_bridge
    import ahb_to_apb_bridge_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 16
) (
    input  logic                  HCLK,
    input  logic                  HRESET,
    input  logic                  HSEL,
    input  logic [ADDR_WIDTH-1:0] HADDR,
    input  logic [1:0]            HTRANS,
    input  logic [2:0]            HSIZE,
    input  logic [3:0]            HPROT,
    input  logic                  HWRITE,
    input  logic                  HREADY,
    input  logic [31:0]           HWDATA,
    output logic                  HREADYOUT,
    output logic                  HRESP,
    output logic [31:0]           HRDATA,
    output logic                  PSEL,
    output logic                  PENABLE,
    output logic [ADDR_WIDTH-1:0] PADDR,
    output logic                  PWRITE,
    output logic [31:0]           PWDATA,
`ifdef AHB2APB_APB4_EN
    output logic [3:0]            PSTRB,
    output logic [2:0]            PPROT,
`endif
    input  logic [31:0]           PRDATA,
    input  logic                  PREADY,
    input  logic                  PSLVERR
);

    bridge_state_e         state_q, state_d;
    logic                  psel_q, psel_d;
    logic                  penable_q, penable_d;
    logic                  hreadyout_q, hreadyout_d;
    logic                  hresp_q, hresp_d;
    logic [ADDR_WIDTH-1:0] paddr_q, paddr_d;
    logic                  pwrite_q, pwrite_d;
    logic [31:0]           pwdata_q, pwdata_d;
    logic [31:0]           hrdata_q, hrdata_d;
    logic                  trans;
    logic                  accept;
    logic                  unused_bits;

    assign trans  = HSEL & is_ahb_active(HTRANS) & HREADY;
    assign accept = trans & ((state_q == StIdle) || (state_q == StErr2));

`ifdef AHB2APB_APB4_EN
    logic [3:0] pstrb_q, pstrb_d;
    logic [2:0] pprot_q, pprot_d;
    logic [3:0] strb_gen;

    ahb_apb_strb_gen u_strb_gen (
        .hsize_i   (HSIZE),
        .addr_lo_i (HADDR[1:0]),
        .write_i   (HWRITE),
        .pstrb_o   (strb_gen)
    );

    always_comb begin
        pstrb_d = pstrb_q;
        pprot_d = pprot_q;
        if (accept) begin
            pstrb_d = strb_gen;
            pprot_d = apb4_pprot(HPROT);
        end
    end

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            pstrb_q <= 4'b0000;
            pprot_q <= 3'b000;
        end else begin
            pstrb_q <= pstrb_d;
            pprot_q <= pprot_d;
        end
    end

    assign PSTRB       = pstrb_q;
    assign PPROT       = pprot_q;
    assign unused_bits = ^{HTRANS[0], HPROT[3:2]};
`else
    assign unused_bits = ^{HTRANS[0], HSIZE, HPROT};
`endif

    // Next state plus all bus outputs, which are registered from the next state.
    always_comb begin
        state_d  = state_q;
        paddr_d  = paddr_q;
        pwrite_d = pwrite_q;
        pwdata_d = pwdata_q;
        hrdata_d = hrdata_q;

        unique case (state_q)
            StIdle, StErr2: begin
                if (accept) begin
                    paddr_d  = HADDR;
                    pwrite_d = HWRITE;
                    state_d  = HWRITE ? StWWait : StSetup;
                end else begin
                    state_d = StIdle;
                end
            end
            StWWait: begin
                pwdata_d = HWDATA;
                state_d  = StSetup;
            end
            StSetup: begin
                state_d = StAccess;
            end
            StAccess: begin
                if (PREADY) begin
                    if (!pwrite_q) begin
                        hrdata_d = PRDATA;
                    end
                    state_d = PSLVERR ? StErr1 : StIdle;
                end
            end
            StErr1: begin
                state_d = StErr2;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        psel_d      = (state_d == StSetup) || (state_d == StAccess);
        penable_d   = (state_d == StAccess);
        hreadyout_d = (state_d == StIdle) || (state_d == StErr2);
        hresp_d     = ((state_d == StErr1) || (state_d == StErr2)) ? HrespError : HrespOkay;
    end

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            state_q     <= StIdle;
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            hreadyout_q <= 1'b1;
            hresp_q     <= HrespOkay;
            paddr_q     <= '0;
            pwrite_q    <= 1'b0;
            pwdata_q    <= 32'h0;
            hrdata_q    <= 32'h0;
        end else begin
            state_q     <= state_d;
            psel_q      <= psel_d;
            penable_q   <= penable_d;
            hreadyout_q <= hreadyout_d;
            hresp_q     <= hresp_d;
            paddr_q     <= paddr_d;
            pwrite_q    <= pwrite_d;
            pwdata_q    <= pwdata_d;
            hrdata_q    <= hrdata_d;
        end
    end

    assign HREADYOUT = hreadyout_q;
    assign HRESP     = hresp_q;
    assign HRDATA    = hrdata_q;
    assign PSEL      = psel_q;
    assign PENABLE   = penable_q;
    assign PADDR     = paddr_q;
    assign PWRITE    = pwrite_q;
    assign PWDATA    = pwdata_q;

endmodule
